// File: rtl/boot_loader_pkg.sv
// Shared types and command codes for the boot-time memory loader.
package boot_loader_pkg;

  typedef enum logic [2:0] {
    ST_CMD,
    ST_ADDR0,
    ST_ADDR1,
    ST_CNT0,
    ST_CNT1,
    ST_DATA,
    ST_RUN,
    ST_ERROR
  } boot_state_t;

  localparam logic [7:0] BL_CMD_IMEM = 8'hA5;
  localparam logic [7:0] BL_CMD_DMEM = 8'h5A;
  localparam logic [7:0] BL_CMD_END  = 8'hFF;

endpackage

// File: rtl/byte_word_packer.sv
// Packs four little-endian bytes into a 32-bit word; word_vld_o fires
// combinationally alongside the 4th byte so the caller can register the write.
module byte_word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr_i,
  input  logic        byte_vld_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_vld_o
);

  logic [1:0]  idx_q, idx_d;
  logic [23:0] shift_q, shift_d;

  always_comb begin
    idx_d   = idx_q;
    shift_d = shift_q;
    if (clr_i) begin
      idx_d   = 2'd0;
      shift_d = 24'd0;
    end else if (byte_vld_i) begin
      idx_d   = idx_q + 2'd1;
      // Newest byte enters at the top so the first byte ends up in [7:0].
      shift_d = {byte_i, shift_q[23:8]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q   <= 2'd0;
      shift_q <= 24'd0;
    end else begin
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  assign word_o     = {byte_i, shift_q};
  assign word_vld_o = byte_vld_i && (idx_q == 2'd3);

endmodule

// File: rtl/boot_loader_ctrl.sv
// Byte-stream section loader for imem/dmem that holds the core in reset
// until the end-of-load command is received.
module boot_loader_ctrl
  import boot_loader_pkg::*;
#(
  parameter int IMEM_DEPTH = 65536,
  parameter int DMEM_DEPTH = 65536,
  localparam int IAW = $clog2(IMEM_DEPTH),
  localparam int DAW = $clog2(DMEM_DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_byte_valid,
  input  logic [7:0]      i_byte,
  output logic            o_byte_ready,
  output logic            o_imem_we,
  output logic [IAW-1:0]  o_imem_addr,
  output logic [31:0]     o_imem_wdata,
  output logic            o_dmem_we,
  output logic [DAW-1:0]  o_dmem_addr,
  output logic [31:0]     o_dmem_wdata,
  output logic            o_core_hold,
  output logic            o_done,
  output logic            o_error
);

  localparam int AW = (IAW > DAW) ? IAW : DAW;
  localparam logic [AW-1:0] IMASK = AW'((64'd1 << IAW) - 64'd1);
  localparam logic [AW-1:0] DMASK = AW'((64'd1 << DAW) - 64'd1);

  boot_state_t    state_q, state_d;
  logic           tgt_dm_q, tgt_dm_d;
  logic [7:0]     alo_q, alo_d;
  logic [7:0]     clo_q, clo_d;
  logic [AW-1:0]  ptr_q, ptr_d;
  logic [15:0]    cnt_q, cnt_d;
  logic           imem_we_q, imem_we_d;
  logic [IAW-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]    imem_wdata_q, imem_wdata_d;
  logic           dmem_we_q, dmem_we_d;
  logic [DAW-1:0] dmem_addr_q, dmem_addr_d;
  logic [31:0]    dmem_wdata_q, dmem_wdata_d;

  logic           hs;
  logic [AW-1:0]  tmask;
  logic [31:0]    word;
  logic           word_vld;

  assign o_byte_ready = (state_q != ST_RUN) && (state_q != ST_ERROR);
  assign hs           = i_byte_valid && o_byte_ready;

  byte_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (state_q != ST_DATA),
    .byte_vld_i (hs && (state_q == ST_DATA)),
    .byte_i     (i_byte),
    .word_o     (word),
    .word_vld_o (word_vld)
  );

  always_comb begin
    state_d      = state_q;
    tgt_dm_d     = tgt_dm_q;
    alo_d        = alo_q;
    clo_d        = clo_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    dmem_we_d    = 1'b0;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    tmask        = tgt_dm_q ? DMASK : IMASK;
    if (hs) begin
      case (state_q)
        ST_CMD: begin
          if (i_byte == BL_CMD_IMEM) begin
            tgt_dm_d = 1'b0;
            state_d  = ST_ADDR0;
          end else if (i_byte == BL_CMD_DMEM) begin
            tgt_dm_d = 1'b1;
            state_d  = ST_ADDR0;
          end else if (i_byte == BL_CMD_END) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_ERROR;
          end
        end
        ST_ADDR0: begin
          alo_d   = i_byte;
          state_d = ST_ADDR1;
        end
        ST_ADDR1: begin
          // Header address is truncated to the selected memory's width.
          ptr_d   = AW'({i_byte, alo_q}) & tmask;
          state_d = ST_CNT0;
        end
        ST_CNT0: begin
          clo_d   = i_byte;
          state_d = ST_CNT1;
        end
        ST_CNT1: begin
          cnt_d   = {i_byte, clo_q};
          state_d = ({i_byte, clo_q} == 16'd0) ? ST_CMD : ST_DATA;
        end
        ST_DATA: begin
          if (word_vld) begin
            if (tgt_dm_q) begin
              dmem_we_d    = 1'b1;
              dmem_addr_d  = ptr_q[DAW-1:0];
              dmem_wdata_d = word;
            end else begin
              imem_we_d    = 1'b1;
              imem_addr_d  = ptr_q[IAW-1:0];
              imem_wdata_d = word;
            end
            ptr_d = (ptr_q + AW'(1)) & tmask;
            cnt_d = cnt_q - 16'd1;
            if (cnt_q == 16'd1) state_d = ST_CMD;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_CMD;
      tgt_dm_q     <= 1'b0;
      alo_q        <= 8'd0;
      clo_q        <= 8'd0;
      ptr_q        <= '0;
      cnt_q        <= 16'd0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= 32'd0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      tgt_dm_q     <= tgt_dm_d;
      alo_q        <= alo_d;
      clo_q        <= clo_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
    end
  end

  assign o_imem_we    = imem_we_q;
  assign o_imem_addr  = imem_addr_q;
  assign o_imem_wdata = imem_wdata_q;
  assign o_dmem_we    = dmem_we_q;
  assign o_dmem_addr  = dmem_addr_q;
  assign o_dmem_wdata = dmem_wdata_q;
  assign o_core_hold  = (state_q != ST_RUN);
  assign o_done       = (state_q == ST_RUN);
  assign o_error      = (state_q == ST_ERROR);

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Randomized scoreboard bench for boot_loader_ctrl: sections are expanded
// into expected memory writes and matched against the DUT write strobes.
module tb_boot_loader_ctrl;

  localparam int IMEM_DEPTH = 65536;
  localparam int DMEM_DEPTH = 65536;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_byte_valid;
  logic [7:0]  i_byte;
  logic        o_byte_ready;
  logic        o_imem_we;
  logic [15:0] o_imem_addr;
  logic [31:0] o_imem_wdata;
  logic        o_dmem_we;
  logic [15:0] o_dmem_addr;
  logic [31:0] o_dmem_wdata;
  logic        o_core_hold;
  logic        o_done;
  logic        o_error;

  boot_loader_ctrl #(.IMEM_DEPTH(IMEM_DEPTH), .DMEM_DEPTH(DMEM_DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_byte_valid (i_byte_valid),
    .i_byte       (i_byte),
    .o_byte_ready (o_byte_ready),
    .o_imem_we    (o_imem_we),
    .o_imem_addr  (o_imem_addr),
    .o_imem_wdata (o_imem_wdata),
    .o_dmem_we    (o_dmem_we),
    .o_dmem_addr  (o_dmem_addr),
    .o_dmem_wdata (o_dmem_wdata),
    .o_core_hold  (o_core_hold),
    .o_done       (o_done),
    .o_error      (o_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          dm;
    int unsigned addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         e_mon;
  logic [31:0] wq[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] last_ia = 0, last_id = 0, last_da = 0, last_dd = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send_byte(logic [7:0] b, int idle);
    repeat (idle) begin
      i_byte_valid = 1'b0;
      i_byte       = 8'($urandom);
      @(posedge clk); #1;
    end
    i_byte_valid = 1'b1;
    i_byte       = b;
    @(posedge clk); #1;
    i_byte_valid = 1'b0;
    i_byte       = 8'($urandom);
  endtask

  // Model: word i of a section lands at (addr + i) mod depth of its target.
  task automatic send_section(logic [7:0] cmd, int unsigned addr, int max_idle);
    int unsigned cnt   = wq.size();
    int unsigned depth = (cmd == 8'h5A) ? DMEM_DEPTH : IMEM_DEPTH;
    wr_t e;
    logic [31:0] w;
    for (int i = 0; i < int'(cnt); i++) begin
      e.dm   = (cmd == 8'h5A);
      e.addr = ((addr % depth) + i) % depth;
      e.data = wq[i];
      exp_q.push_back(e);
    end
    send_byte(cmd, $urandom_range(max_idle, 0));
    send_byte(addr[7:0], $urandom_range(max_idle, 0));
    send_byte(addr[15:8], $urandom_range(max_idle, 0));
    send_byte(cnt[7:0], $urandom_range(max_idle, 0));
    send_byte(cnt[15:8], $urandom_range(max_idle, 0));
    for (int i = 0; i < int'(cnt); i++) begin
      w = wq[i];
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], $urandom_range(max_idle, 0));
    end
  endtask

  task automatic check_reset_vals(string tag);
    chk({tag, "_ready"}, o_byte_ready, 1);
    chk({tag, "_hold"}, o_core_hold, 1);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_error"}, o_error, 0);
    chk({tag, "_imem_we"}, o_imem_we, 0);
    chk({tag, "_dmem_we"}, o_dmem_we, 0);
    chk({tag, "_imem_addr"}, o_imem_addr, 0);
    chk({tag, "_imem_wdata"}, o_imem_wdata, 0);
    chk({tag, "_dmem_addr"}, o_dmem_addr, 0);
    chk({tag, "_dmem_wdata"}, o_dmem_wdata, 0);
  endtask

  task automatic drain(string tag);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_pending_writes"}, exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (o_imem_we && o_dmem_we) begin
      n_chk++; n_fail++;
      $display("FAIL both_we: got both strobes high, required at most one at %0t", $time);
    end
    if (o_imem_we || o_dmem_we) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_write: got imem_we=%0b dmem_we=%0b, required none at %0t",
                 o_imem_we, o_dmem_we, $time);
      end else begin
        e_mon = exp_q.pop_front();
        chk("wr_target_dmem", o_dmem_we, e_mon.dm);
        if (e_mon.dm) begin
          chk("dmem_addr", o_dmem_addr, e_mon.addr);
          chk("dmem_wdata", o_dmem_wdata, e_mon.data);
          chk("imem_addr_hold", o_imem_addr, last_ia);
          chk("imem_wdata_hold", o_imem_wdata, last_id);
          last_da = e_mon.addr; last_dd = e_mon.data;
        end else begin
          chk("imem_addr", o_imem_addr, e_mon.addr);
          chk("imem_wdata", o_imem_wdata, e_mon.data);
          chk("dmem_addr_hold", o_dmem_addr, last_da);
          chk("dmem_wdata_hold", o_dmem_wdata, last_dd);
          last_ia = e_mon.addr; last_id = e_mon.data;
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset        = 1'b1;
    i_byte_valid = 1'b0;
    i_byte       = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("in_reset");
    reset = 1'b0;
    @(posedge clk); #1;
    check_reset_vals("after_reset");

    wq = '{32'h0000_0013, 32'h0010_0093};
    send_section(8'hA5, 0, 0);
    drain("imem_plan");

    wq = '{32'hDEAD_BEEF};
    send_section(8'h5A, 16'h0010, 3);
    drain("dmem_plan");

    wq = '{32'($urandom), 32'($urandom)};
    send_section(8'hA5, 16'hFFFF, 1);
    drain("wrap");

    repeat (12) begin
      logic [7:0] cmd;
      int n;
      cmd = ($urandom_range(1, 0) == 1) ? 8'hA5 : 8'h5A;
      n   = $urandom_range(5, 0);
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back($urandom);
      send_section(cmd, $urandom_range(65535, 0), $urandom_range(2, 0));
    end
    drain("random_sections");

    wq.delete();
    send_section(8'hA5, 0, 0);
    drain("zero_count");

    send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("mid_reset");
    last_ia = 0; last_id = 0; last_da = 0; last_dd = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check_reset_vals("post_mid_reset");
    wq = '{32'($urandom), 32'($urandom)};
    send_section(8'h5A, 16'h0123, 1);
    drain("fresh_after_reset");

    wq.delete();
    send_section(8'hA5, 0, 0);
    send_byte(8'hFF, 0);
    chk("run_hold", o_core_hold, 0);
    chk("run_done", o_done, 1);
    chk("run_ready", o_byte_ready, 0);
    chk("run_error", o_error, 0);
    foreach (wq[i]) ;
    send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 0);
    send_byte(8'h33, 0);
    chk("run_sticky_done", o_done, 1);
    chk("run_sticky_hold", o_core_hold, 0);
    chk("run_sticky_error", o_error, 0);
    drain("run_no_writes");

    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    last_ia = 0; last_id = 0; last_da = 0; last_dd = 0;
    @(posedge clk); #1;
    send_byte(8'h33, 0);
    chk("err_error", o_error, 1);
    chk("err_hold", o_core_hold, 1);
    chk("err_ready", o_byte_ready, 0);
    chk("err_done", o_done, 0);
    send_byte(8'hFF, 0);
    send_byte(8'hA5, 1);
    chk("err_sticky_error", o_error, 1);
    chk("err_sticky_done", o_done, 0);
    drain("err_no_writes");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
